pmp_mem_arbiter: RTL

Shares one memory port between the instruction-fetch and load/store requesters. Every access is gated by a single shared PMP check port before it reaches memory. Sits between fetch/LSU and the memory/bus side, next to the PMP checker. Sequences each transaction as capture, arbitrate, PMP check, memory access, then response, and raises an access-fault response without touching memory when the check fails.

---
 rtl/pmp_mem_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pmp_mem_arbiter.sv
// Shared memory port arbiter for fetch and load/store, gated by one PMP check.
// Sequence: capture -> arbitrate -> PMP check -> memory access -> response.
//
// Ports:
//   clock, reset           clock, synchronous active-low reset
//   imem_in / imem_out     fetch request / response
//   dmem_in / dmem_out     load/store request / response
//   chk_valid .. chk_write PMP check request, chk_error is its same-cycle result
//   mem_in / mem_out       shared memory request / response
package pmp_mem_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [1:0]  mem_mode;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

endpackage

module pmp_mem_arbiter
    import pmp_mem_pkg::*;
#(
    parameter int ACCESS_TIMEOUT = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        chk_valid,
    output logic [31:0] chk_addr,
    output logic [1:0]  chk_mode,
    output logic        chk_instr,
    output logic        chk_write,
    input  logic        chk_error,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LIM = TO_WIDTH'(ACCESS_TIMEOUT);

    state_t              state;
    state_t              state_nxt;
    mem_in_type          ibuf;
    mem_in_type          dbuf;
    mem_in_type          req;
    mem_in_type          mem_hold;
    logic                ibuf_v;
    logic                dbuf_v;
    // Current grant (1 = D); it also serves as last_grant for the tie-break.
    logic                gnt_d;
    logic                gnt_nxt;
    logic [TO_WIDTH-1:0] cnt;
    logic                cnt_inc;
    logic                ld_hold;
    logic                ld_rsp;
    logic                rsp_error;
    logic                rsp_error_nxt;
    logic [31:0]         rsp_rdata;
    logic [31:0]         rsp_rdata_nxt;

    assign req = gnt_d ? dbuf : ibuf;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt_d;
        cnt_inc       = 1'b0;
        ld_hold       = 1'b0;
        ld_rsp        = 1'b0;
        rsp_error_nxt = 1'b0;
        rsp_rdata_nxt = '0;
        chk_valid     = 1'b0;
        chk_addr      = '0;
        chk_mode      = '0;
        chk_instr     = 1'b0;
        chk_write     = 1'b0;
        mem_in           = mem_hold;
        mem_in.mem_valid = 1'b0;
        imem_out      = '0;
        dmem_out      = '0;
        unique case (state)
            IDLE: begin
                if (ibuf_v || dbuf_v) begin
                    gnt_nxt   = dbuf_v && (!ibuf_v || !gnt_d);
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                chk_valid = 1'b1;
                chk_addr  = req.mem_addr;
                chk_mode  = req.mem_mode;
                chk_instr = req.mem_instr;
                chk_write = |req.mem_wstrb;
                if (chk_error) begin
                    ld_rsp        = 1'b1;
                    rsp_error_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    ld_hold   = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_in.mem_valid = 1'b1;
                if (mem_out.mem_ready) begin
                    ld_rsp        = 1'b1;
                    rsp_error_nxt = mem_out.mem_error;
                    rsp_rdata_nxt = mem_out.mem_rdata;
                    state_nxt     = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_out.mem_ready) begin
                    ld_rsp        = 1'b1;
                    rsp_error_nxt = mem_out.mem_error;
                    rsp_rdata_nxt = mem_out.mem_rdata;
                    state_nxt     = RESP;
                end else if (ACCESS_TIMEOUT != 0 &&
                             cnt + TO_WIDTH'(1) == TO_LIM) begin
                    ld_rsp        = 1'b1;
                    rsp_error_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (gnt_d) begin
                    dmem_out.mem_ready = 1'b1;
                    dmem_out.mem_error = rsp_error;
                    dmem_out.mem_rdata = rsp_rdata;
                end else begin
                    imem_out.mem_ready = 1'b1;
                    imem_out.mem_error = rsp_error;
                    imem_out.mem_rdata = rsp_rdata;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ibuf_v    <= 1'b0;
            dbuf_v    <= 1'b0;
            ibuf      <= '0;
            dbuf      <= '0;
            gnt_d     <= 1'b1;
            mem_hold  <= '0;
            cnt       <= '0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // A full buffer ignores pulses; the granted one clears in RESP.
            if (state == RESP && !gnt_d) begin
                ibuf_v <= 1'b0;
            end else if (imem_in.mem_valid && !ibuf_v) begin
                ibuf_v <= 1'b1;
                ibuf   <= imem_in;
            end
            if (state == RESP && gnt_d) begin
                dbuf_v <= 1'b0;
            end else if (dmem_in.mem_valid && !dbuf_v) begin
                dbuf_v <= 1'b1;
                dbuf   <= dmem_in;
            end
            gnt_d <= gnt_nxt;
            if (ld_hold) begin
                mem_hold <= req;
            end
            if (ld_rsp) begin
                rsp_error <= rsp_error_nxt;
                rsp_rdata <= rsp_rdata_nxt;
            end
            if (state == RESP) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + TO_WIDTH'(1);
            end
        end
    end

endmodule
